reference_buffer_reader: RTL and testbench

- Initiator for the reference buffer's index/data interface: on `start`, it sweeps indices 0..BUFFER_LENGTH-1 and issues one index request at a time.
- Captures each returned I/Q sample and forwards it as a valid/ready stream to downstream CAF logic (correlator / cpx multiply).
- Replaces bench-driven indexing with synthesizable RTL, so the reference buffer can be replayed under backpressure.

---
 rtl/reference_buffer_reader_if.sv | 28 ++
 rtl/reference_buffer_reader.sv | 81 ++++++++
 tb/tb_reference_buffer_reader.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reference_buffer_reader_if.sv
// Index/data bus toward the reference buffer plus the sample stream toward the CAF logic.
// master = reader side, slave = buffer/downstream side.
interface reference_buffer_reader_if #(
    parameter int INDEX_BITS = 8,
    parameter int I_BITS     = 12,
    parameter int Q_BITS     = 12
);
    logic [INDEX_BITS-1:0]    m_axi_index_rdata;
    logic                     m_axi_rvalid;
    logic                     m_axi_rready;
    logic                     s_axi_data_rvalid;
    logic signed [I_BITS-1:0] i_in;
    logic signed [Q_BITS-1:0] q_in;
    logic signed [I_BITS-1:0] out_i;
    logic signed [Q_BITS-1:0] out_q;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output m_axi_index_rdata, m_axi_rvalid, m_axi_rready, out_i, out_q, out_valid,
        input  s_axi_data_rvalid, i_in, q_in, out_ready
    );

    modport slave (
        input  m_axi_index_rdata, m_axi_rvalid, m_axi_rready, out_i, out_q, out_valid,
        output s_axi_data_rvalid, i_in, q_in, out_ready
    );
endinterface

// File: rtl/reference_buffer_reader.sv
// Sweeps the reference buffer indices 0..BUFFER_LENGTH-1, one outstanding request at a time,
// and replays the returned I/Q samples as a valid/ready stream.
module reference_buffer_reader #(
    parameter int BUFFER_LENGTH = 256,
    parameter int INDEX_BITS    = 8,
    parameter int I_BITS        = 12,
    parameter int Q_BITS        = 12
) (
    input  logic clk,
    input  logic n_reset,
    input  logic start,
    output logic busy,
    output logic done,
    reference_buffer_reader_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, GAP, DRAIN} state_t;

    localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(BUFFER_LENGTH - 1);
    localparam logic [INDEX_BITS-1:0] ONE      = INDEX_BITS'(1);

    state_t                 state, state_nxt;
    logic [INDEX_BITS-1:0]  idx;
    logic                   free, capture, consume, last;

    always_comb begin
        free    = !bus.out_valid || bus.out_ready;
        consume = bus.out_valid && bus.out_ready;
        capture = (state == REQ) && bus.s_axi_data_rvalid && bus.m_axi_rready && free;
        last    = (idx == LAST_IDX);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) state <= IDLE;
        else          state <= state_nxt;
    end

    // GAP is the one idle cycle between a capture and the next request
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)   state_nxt = REQ;
            REQ:     if (capture) state_nxt = last ? DRAIN : GAP;
            GAP:                  state_nxt = REQ;
            DRAIN:   if (consume) state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    assign bus.m_axi_rvalid      = (state == REQ);
    assign bus.m_axi_index_rdata = idx;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            idx              <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            bus.m_axi_rready <= 1'b0;
            bus.out_i        <= '0;
            bus.out_q        <= '0;
            bus.out_valid    <= 1'b0;
        end else begin
            // one-cycle-late view of output-register space, muted outside an active sweep
            bus.m_axi_rready <= ((state_nxt == REQ) || (state_nxt == GAP)) && free;
            done             <= (state == DRAIN) && consume;

            if ((state == IDLE) && start)         busy <= 1'b1;
            else if ((state == DRAIN) && consume) busy <= 1'b0;

            if ((state == IDLE) && start) idx <= '0;
            else if (capture && !last)    idx <= idx + ONE;

            if (capture) begin
                bus.out_i     <= bus.i_in[I_BITS-1:0];
                bus.out_q     <= bus.q_in[Q_BITS-1:0];
                bus.out_valid <= 1'b1;
            end else if (consume) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_reference_buffer_reader.sv
// Randomized bench: two readers (4-entry and 256-entry buffers) against an in-order
// sample scoreboard and a behavioural reference buffer.
module tb_reference_buffer_reader;
    logic clk = 1'b0;
    logic n_reset;
    logic start_a, start_b, busy_a, busy_b, done_a, done_b;
    logic junk_a, rnd_rdy, rdy_a;

    always #5 clk = ~clk;

    reference_buffer_reader_if #(.INDEX_BITS(2), .I_BITS(12), .Q_BITS(12)) bus_a();
    reference_buffer_reader_if #(.INDEX_BITS(8), .I_BITS(12), .Q_BITS(12)) bus_b();

    reference_buffer_reader #(.BUFFER_LENGTH(4), .INDEX_BITS(2), .I_BITS(12), .Q_BITS(12)) dut_a (
        .clk(clk), .n_reset(n_reset), .start(start_a), .busy(busy_a), .done(done_a), .bus(bus_a));
    reference_buffer_reader #(.BUFFER_LENGTH(256), .INDEX_BITS(8), .I_BITS(12), .Q_BITS(12)) dut_b (
        .clk(clk), .n_reset(n_reset), .start(start_b), .busy(busy_b), .done(done_b), .bus(bus_b));

    int n_chk = 0, n_err = 0;
    logic signed [11:0] mem_i [2][256];
    logic signed [11:0] mem_q [2][256];
    int   acc [2] = '{0, 0};
    int   base [2] = '{0, 0};
    int   done_cnt [2] = '{0, 0};
    int   max_idx [2] = '{0, 0};
    logic saw_min [2] = '{1'b0, 1'b0};

    task automatic chk(string tag, logic signed [31:0] got, logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference buffer: answers a request one cycle later with the stored sample
    always @(posedge clk) begin
        if (junk_a) begin
            bus_a.s_axi_data_rvalid <= 1'b1;
            bus_a.i_in <= 12'sh7FF;
            bus_a.q_in <= 12'sh7FF;
        end else if (bus_a.m_axi_rvalid) begin
            bus_a.s_axi_data_rvalid <= 1'b1;
            bus_a.i_in <= mem_i[0][bus_a.m_axi_index_rdata];
            bus_a.q_in <= mem_q[0][bus_a.m_axi_index_rdata];
        end else begin
            bus_a.s_axi_data_rvalid <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (bus_b.m_axi_rvalid && ($urandom_range(0, 2) != 0)) begin
            bus_b.s_axi_data_rvalid <= 1'b1;
            bus_b.i_in <= mem_i[1][bus_b.m_axi_index_rdata];
            bus_b.q_in <= mem_q[1][bus_b.m_axi_index_rdata];
        end else begin
            bus_b.s_axi_data_rvalid <= 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        bus_a.out_ready = rdy_a;
        bus_b.out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // Scoreboard: the sweep must deliver buffer[0..L-1] in order, exactly once each
    task automatic mon(int k, int len, logic ov, logic ordy, logic signed [11:0] oi,
                       logic signed [11:0] oq, logic rv, int ix, logic dn, logic bsy);
        int pos;
        pos = acc[k] - base[k];
        if (rv) begin
            chk("req_idx", ix, pos + (ov ? 1 : 0));
            if (ix > max_idx[k]) max_idx[k] = ix;
        end
        if (ov && ordy) begin
            if (pos >= len) chk("extra_sample", pos, len - 1);
            else begin
                chk("out_i", oi, mem_i[k][pos]);
                chk("out_q", oq, mem_q[k][pos]);
                if (oi === 12'h800) saw_min[k] = 1'b1;
            end
            acc[k]++;
        end
        if (dn) begin
            done_cnt[k]++;
            chk("done_pos", acc[k] - base[k], len);
            chk("busy_at_done", bsy, 0);
        end
    endtask

    always @(negedge clk) begin
        mon(0, 4, bus_a.out_valid, bus_a.out_ready, bus_a.out_i, bus_a.out_q,
            bus_a.m_axi_rvalid, int'(bus_a.m_axi_index_rdata), done_a, busy_a);
        mon(1, 256, bus_b.out_valid, bus_b.out_ready, bus_b.out_i, bus_b.out_q,
            bus_b.m_axi_rvalid, int'(bus_b.m_axi_index_rdata), done_b, busy_b);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(int k);
        tick();
        if (k == 0) start_a = 1'b1;
        else        start_b = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(int k, int target, int budget, string tag);
        int n = 0;
        while (done_cnt[k] < target && n < budget) begin
            tick();
            n++;
        end
        chk(tag, done_cnt[k], target);
    endtask

    task automatic check_zero_a(string tag);
        chk({tag, "_busy"},   busy_a, 0);
        chk({tag, "_done"},   done_a, 0);
        chk({tag, "_rvalid"}, bus_a.m_axi_rvalid, 0);
        chk({tag, "_rready"}, bus_a.m_axi_rready, 0);
        chk({tag, "_index"},  bus_a.m_axi_index_rdata, 0);
        chk({tag, "_out_i"},  bus_a.out_i, 0);
        chk({tag, "_out_q"},  bus_a.out_q, 0);
        chk({tag, "_ovalid"}, bus_a.out_valid, 0);
    endtask

    initial begin
        int n;
        n_reset = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        junk_a  = 1'b0;
        rnd_rdy = 1'b0;
        rdy_a   = 1'b1;
        for (int i = 0; i < 256; i++) begin
            mem_i[0][i] = 12'(i + 1);
            mem_q[0][i] = 12'(-(i + 1));
            mem_i[1][i] = 12'($urandom);
            mem_q[1][i] = 12'($urandom);
        end
        mem_i[1][100] = 12'sh800;
        mem_q[1][200] = 12'sh800;
        mem_i[1][255] = 12'sh7FF;

        repeat (3) @(posedge clk);
        #1;
        check_zero_a("rst");
        chk("rst_b_busy", busy_b, 0);
        chk("rst_b_ovalid", bus_b.out_valid, 0);
        n_reset = 1'b1;

        // 1: plain sweep, zero-wait buffer, downstream always ready
        base[0] = acc[0];
        pulse_start(0);
        chk("t1_busy", busy_a, 1);
        wait_done(0, 1, 200, "t1_done");
        chk("t1_count", acc[0] - base[0], 4);
        repeat (5) tick();
        chk("t1_single_done", done_cnt[0], 1);
        chk("t1_busy_low", busy_a, 0);

        // 2: downstream stall right after the first capture
        base[0] = acc[0];
        rdy_a = 1'b0;
        pulse_start(0);
        n = 0;
        while (!bus_a.out_valid && n < 50) begin tick(); n++; end
        chk("t2_first_cap", bus_a.out_valid, 1);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t2_hold_i", bus_a.out_i, mem_i[0][0]);
            chk("t2_hold_q", bus_a.out_q, mem_q[0][0]);
            chk("t2_hold_v", bus_a.out_valid, 1);
            chk("t2_rready", bus_a.m_axi_rready, 0);
            chk("t2_idx", bus_a.m_axi_index_rdata, 1);
        end
        rdy_a = 1'b1;
        wait_done(0, 2, 200, "t2_done");
        chk("t2_count", acc[0] - base[0], 4);

        // 3: spurious data beats while idle and while draining
        junk_a = 1'b1;
        repeat (3) tick();
        junk_a = 1'b0;
        repeat (2) tick();
        chk("t3_idle_ovalid", bus_a.out_valid, 0);
        chk("t3_idle_idx", bus_a.m_axi_index_rdata, 3);
        chk("t3_idle_busy", busy_a, 0);
        chk("t3_idle_done", done_cnt[0], 2);
        base[0] = acc[0];
        pulse_start(0);
        n = 0;
        while (acc[0] - base[0] < 3 && n < 100) begin tick(); n++; end
        rdy_a = 1'b0;
        n = 0;
        while (!(bus_a.out_valid && !bus_a.m_axi_rvalid && bus_a.m_axi_index_rdata == 2'd3) && n < 50) begin
            tick();
            n++;
        end
        chk("t3_drain_reached", n < 50, 1);
        junk_a = 1'b1;
        repeat (3) tick();
        junk_a = 1'b0;
        repeat (2) tick();
        chk("t3_drain_i", bus_a.out_i, mem_i[0][3]);
        chk("t3_drain_q", bus_a.out_q, mem_q[0][3]);
        chk("t3_drain_busy", busy_a, 1);
        chk("t3_drain_done", done_cnt[0], 2);
        rdy_a = 1'b1;
        wait_done(0, 3, 200, "t3_done");

        // 4: reset in the middle of a sweep
        base[0] = acc[0];
        pulse_start(0);
        n = 0;
        while (!(bus_a.m_axi_index_rdata == 2'd2 && bus_a.out_valid) && n < 50) begin tick(); n++; end
        chk("t4_mid_reached", n < 50, 1);
        #2;
        n_reset = 1'b0;
        #1;
        check_zero_a("t4_async");
        base[0] = acc[0];
        repeat (2) @(posedge clk);
        #1;
        n_reset = 1'b1;
        pulse_start(0);
        chk("t4_restart_idx", bus_a.m_axi_index_rdata, 0);
        chk("t4_restart_rvalid", bus_a.m_axi_rvalid, 1);
        wait_done(0, 4, 200, "t4_done");
        chk("t4_count", acc[0] - base[0], 4);

        // 5: second start while the sweep is running
        base[0] = acc[0];
        pulse_start(0);
        n = 0;
        while (bus_a.m_axi_index_rdata != 2'd1 && n < 50) begin tick(); n++; end
        pulse_start(0);
        wait_done(0, 5, 200, "t5_done");
        chk("t5_count", acc[0] - base[0], 4);
        repeat (5) tick();
        chk("t5_single_done", done_cnt[0], 5);

        // 6: full 256-entry sweep, random buffer latency and random backpressure
        rnd_rdy = 1'b1;
        base[1] = acc[1];
        pulse_start(1);
        wait_done(1, 1, 20000, "t6_done");
        rnd_rdy = 1'b0;
        chk("t6_count", acc[1] - base[1], 256);
        chk("t6_max_idx", max_idx[1], 255);
        chk("t6_min_i_seen", saw_min[1], 1);
        repeat (5) tick();
        chk("t6_single_done", done_cnt[1], 1);
        chk("t6_final_idx", bus_b.m_axi_index_rdata, 255);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
